alu_issue_ctrl: RTL and testbench
=================================

// Module: alu_issue_ctrl
// PURPOSE
//  Issue controller for the 16-bit ALU. Accepts one instruction per valid/ready handshake.
//  Reads both operands from the register file and presents opcode and operands to the ALU.
//  Waits out the ALU's registered latency, then writes the result back to the register file
//  and commits PSR flags. STORE results go out on a separate store handshake.
//  Sits between the instruction source (front end) and the ALU + register file.
// PARAMETERS
//  DATA_W   16  operand/result width
//  REG_AW   4   register-file address width
//  ALU_LAT  1   ALU result latency in clock edges (>=1); counted in EXEC
// PORTS
//  clock        in   1        system clock, rising edge
//  reset        in   1        asynchronous, active-low reset
//  instr_valid  in   1        instruction offered
//  instr_ready  out  1        controller can accept (IDLE only)
//  instr_op     in   8        opcode, ALU encoding
//  instr_rd     in   REG_AW   destination / operand-A register
//  instr_rs     in   REG_AW   operand-B register
//  rf_raddr_a   out  REG_AW   RF read address A (combinational RF read)
//  rf_raddr_b   out  REG_AW   RF read address B
//  rf_rdata_a   in   DATA_W   RF read data A
//  rf_rdata_b   in   DATA_W   RF read data B
//  alu_opcode   out  8        to ALU; 8'h00 whenever not in ISSUE
//  alu_data_a   out  DATA_W   to ALU operand A
//  alu_data_b   out  DATA_W   to ALU operand B
//  alu_result   in   DATA_W   from ALU (registered)
//  alu_psr      in   5        from ALU flags (registered, sticky)
//  rf_we        out  1        RF write strobe, one cycle
//  rf_waddr     out  REG_AW   RF write address (= captured rd)
//  rf_wdata     out  DATA_W   RF write data (= alu_result)
//  psr_q        out  5        committed PSR
//  st_valid     out  1        STORE data offered
//  st_ready     in   1        STORE consumer accepts
//  st_data      out  DATA_W   STORE data (= alu_result)
//  illegal      out  1        one-cycle pulse: opcode outside the supported set
// BEHAVIOUR
//  Reset (async, low): state=IDLE, lat_cnt=0, psr_q=0, captured instr=0. All outputs 0
//   except instr_ready=1 once reset deasserts. Reset mid-operation abandons the instruction:
//   no rf_we, no st_valid, no psr update.
//  FSM: IDLE -> ISSUE -> EXEC -> WB -> IDLE.
//  IDLE: instr_ready=1. On valid&ready, capture op/rd/rs and go to ISSUE.
//  ISSUE (1 cycle): rf_raddr_a=rd, rf_raddr_b=rs; alu_opcode=op, alu_data_a/b=rf_rdata_a/b.
//   The ALU samples these at the ISSUE-ending edge. lat_cnt loads ALU_LAT-1. Go to EXEC.
//  EXEC: alu_opcode=0. Decrement lat_cnt; when lat_cnt==0, go to WB.
//  WB, by class:
//   WR    (01,02,03,05,06,09,0D, 8x, Fx): rf_we=1 for 1 cycle, then IDLE.
//   FLAG  (0B CMP): no rf_we.
//   ST    (44): st_valid=1, held with st_data stable until st_ready. Then IDLE; no rf_we.
//   ILL   (all other opcodes): illegal=1 for 1 cycle, then IDLE; no writes.
//   PSR: psr_q <= alu_psr at WB exit for 05 (ADD) and 0B (CMP) only; otherwise held.
//  Latency (ALU_LAT=1): accept edge E; ISSUE E..E+1; EXEC E+1..E+2; WB E+2..E+3.
//   rf_we is high in cycle E+2..E+3; instr_ready returns at E+3.
//   Peak throughput: one instruction per 4 cycles.
//  instr_valid held while busy: instr_ready stays 0, nothing is captured, no loss.
//  Back-to-back dependency (rd of N = source of N+1) is safe. The RF write lands before
//   N+1's ISSUE, so no forwarding is needed.
//  Widths: results pass through unmodified. alu_result bit 16 is not visible; no carry is
//   generated here.
//  st_ready high outside WB(ST) is ignored. st_valid never drops without st_ready.
// STRUCTURE
//  Shared package alu_pkg: opcode localparams (OP_AND..OP_LUI), op-class enum
//   {WR,FLAG,ST,ILL}, FSM state encoding, PSR bit indices.
//  Sub-module alu_op_decode: combinational op[7:0] -> {class, psr_commit}.
//   It is shared with the front end's hazard logic.
// TESTING
//  1 R1=0x0003, R2=0x0004, ADD(05) rd=1 rs=2 -> rf_we at accept+2 cycles,
//    waddr=1, wdata=0x0007. psr_q updated. instr_ready low for 3 cycles.
//  2 R3=0x1234, R4=0x1234, CMP(0B) -> no rf_we; psr_q[3]=1 after WB. Then ADDU(06):
//    psr_q unchanged.
//  3 STORE(44) rd=5 (R5=0xBEEF), st_ready low 4 cycles then high -> st_valid held 5 cycles,
//    st_data=0xBEEF throughout; no rf_we.
//  4 Back-to-back ADDU R1+=R2 twice with instr_valid held high -> second op sees the first
//    result; second accept exactly 4 cycles after the first.
//  5 Opcode 0x07 -> illegal pulse 1 cycle, no rf_we/st_valid, psr_q unchanged.
//  6 Assert reset in EXEC of a SUB -> outputs 0 immediately. After release: IDLE,
//    instr_ready=1, no write ever issued.

Source files
------------

// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: shared opcodes, op classes, FSM states and PSR bit positions for the ALU issue path
package alu_pkg;
  localparam logic [7:0] OP_AND  = 8'h01;
  localparam logic [7:0] OP_OR   = 8'h02;
  localparam logic [7:0] OP_XOR  = 8'h03;
  localparam logic [7:0] OP_ADD  = 8'h05;
  localparam logic [7:0] OP_ADDU = 8'h06;
  localparam logic [7:0] OP_SUB  = 8'h09;
  localparam logic [7:0] OP_CMP  = 8'h0B;
  localparam logic [7:0] OP_MOV  = 8'h0D;
  localparam logic [7:0] OP_STOR = 8'h44;
  localparam logic [7:0] OP_SHL  = 8'h80;
  localparam logic [7:0] OP_LUI  = 8'hF0;
  typedef enum logic [1:0] {CLS_WR, CLS_FLAG, CLS_ST, CLS_ILL} op_class_t;
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_EXEC, S_WB} state_t;
  localparam int PSR_C = 0;
  localparam int PSR_L = 1;
  localparam int PSR_F = 2;
  localparam int PSR_Z = 3;
  localparam int PSR_N = 4;
  localparam int PSR_W = 5;
endpackage

// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if: instruction, register-file, ALU and store signals around the issue controller
interface alu_issue_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int REG_AW = 4
);
  logic              instr_valid;
  logic              instr_ready;
  logic [7:0]        instr_op;
  logic [REG_AW-1:0] instr_rd;
  logic [REG_AW-1:0] instr_rs;
  logic [REG_AW-1:0] rf_raddr_a;
  logic [REG_AW-1:0] rf_raddr_b;
  logic [DATA_W-1:0] rf_rdata_a;
  logic [DATA_W-1:0] rf_rdata_b;
  logic [7:0]        alu_opcode;
  logic [DATA_W-1:0] alu_data_a;
  logic [DATA_W-1:0] alu_data_b;
  logic [DATA_W-1:0] alu_result;
  logic [4:0]        alu_psr;
  logic              rf_we;
  logic [REG_AW-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [4:0]        psr_q;
  logic              st_valid;
  logic              st_ready;
  logic [DATA_W-1:0] st_data;
  logic              illegal;
  modport master (
    input  instr_valid, instr_op, instr_rd, instr_rs, rf_rdata_a, rf_rdata_b,
           alu_result, alu_psr, st_ready,
    output instr_ready, rf_raddr_a, rf_raddr_b, alu_opcode, alu_data_a, alu_data_b,
           rf_we, rf_waddr, rf_wdata, psr_q, st_valid, st_data, illegal
  );
  modport slave (
    output instr_valid, instr_op, instr_rd, instr_rs, rf_rdata_a, rf_rdata_b,
           alu_result, alu_psr, st_ready,
    input  instr_ready, rf_raddr_a, rf_raddr_b, alu_opcode, alu_data_a, alu_data_b,
           rf_we, rf_waddr, rf_wdata, psr_q, st_valid, st_data, illegal
  );
endinterface

// File: rtl/alu_issue_ctrl_decode.sv
// alu_op_decode: opcode to write-back class and PSR-commit flag, shared with front-end hazard logic
module alu_op_decode
  import alu_pkg::*;
(
  input  logic [7:0] op,
  output op_class_t  cls,
  output logic       psr_commit
);
  logic wr;
  assign wr = op inside {OP_AND, OP_OR, OP_XOR, OP_ADD, OP_ADDU, OP_SUB, OP_MOV}
              || op[7:4] == OP_SHL[7:4] || op[7:4] == OP_LUI[7:4];
  assign cls = wr ? CLS_WR : op == OP_CMP ? CLS_FLAG : op == OP_STOR ? CLS_ST : CLS_ILL;
  assign psr_commit = op == OP_ADD || op == OP_CMP;
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: sequences one instruction at a time through RF read, ALU latency and write-back/store
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int REG_AW  = 4,
  parameter int ALU_LAT = 1
) (
  input logic           clock,
  input logic           reset,
  alu_issue_ctrl_if.master bus
);
  localparam int LW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  state_t            state, state_nx;
  logic [7:0]        op_q;
  logic [REG_AW-1:0] rd_q, rs_q;
  logic [LW-1:0]     lat_cnt;
  logic [4:0]        psr_r;
  op_class_t         cls;
  logic              psr_commit;
  logic              accept, wb_done;
  alu_op_decode u_dec (.op(op_q), .cls(cls), .psr_commit(psr_commit));
  assign accept  = state == S_IDLE && bus.instr_valid;
  // a store only retires once the consumer takes the data
  assign wb_done = state == S_WB && (cls != CLS_ST || bus.st_ready);
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= S_IDLE;
      op_q    <= '0;
      rd_q    <= '0;
      rs_q    <= '0;
      lat_cnt <= '0;
      psr_r   <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_q <= bus.instr_op;
        rd_q <= bus.instr_rd;
        rs_q <= bus.instr_rs;
      end
      lat_cnt <= state == S_ISSUE ? LW'(ALU_LAT - 1)
               : (state == S_EXEC && lat_cnt != '0) ? lat_cnt - LW'(1) : lat_cnt;
      if (wb_done && psr_commit) psr_r <= bus.alu_psr;
    end
  end
  always_comb begin
    state_nx        = state;
    bus.instr_ready = 1'b0;
    bus.rf_raddr_a  = '0;
    bus.rf_raddr_b  = '0;
    bus.alu_opcode  = '0;
    bus.alu_data_a  = '0;
    bus.alu_data_b  = '0;
    bus.rf_we       = 1'b0;
    bus.st_valid    = 1'b0;
    bus.illegal     = 1'b0;
    case (state)
      S_IDLE: begin
        bus.instr_ready = reset;
        state_nx        = bus.instr_valid ? S_ISSUE : S_IDLE;
      end
      S_ISSUE: begin
        bus.rf_raddr_a = rd_q;
        bus.rf_raddr_b = rs_q;
        bus.alu_opcode = op_q;
        bus.alu_data_a = bus.rf_rdata_a;
        bus.alu_data_b = bus.rf_rdata_b;
        state_nx       = S_EXEC;
      end
      S_EXEC: state_nx = lat_cnt == '0 ? S_WB : S_EXEC;
      S_WB: begin
        bus.rf_we    = cls == CLS_WR;
        bus.st_valid = cls == CLS_ST;
        bus.illegal  = cls == CLS_ILL;
        state_nx     = wb_done ? S_IDLE : S_WB;
      end
      default: state_nx = S_IDLE;
    endcase
  end
  assign bus.rf_waddr = rd_q;
  assign bus.rf_wdata = bus.alu_result;
  assign bus.st_data  = bus.alu_result;
  assign bus.psr_q    = psr_r;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: register file and ALU stand-ins plus a transaction-level reference for the issue controller
module tb_alu_issue_ctrl;
  localparam int DW  = 16;
  localparam int AW  = 4;
  localparam int LAT = 1;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;
  alu_issue_ctrl_if #(.DATA_W(DW), .REG_AW(AW)) bus ();
  alu_issue_ctrl #(.DATA_W(DW), .REG_AW(AW), .ALU_LAT(LAT)) dut (.clock(clock), .reset(reset), .bus(bus));
  logic          pl_en = 1'b0;
  logic [AW-1:0] pl_addr = '0;
  logic [DW-1:0] pl_data = '0;
  logic [DW-1:0] rf [16] = '{default: '0};
  function automatic logic [DW-1:0] alu_res(logic [7:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    case (op)
      8'h01: return a & b;
      8'h02: return a | b;
      8'h03: return a ^ b;
      8'h05, 8'h06: return a + b;
      8'h09: return a - b;
      8'h0D: return b;
      8'h0B, 8'h44: return a;
      default: return op[7:4] == 4'h8 ? a << b[3:0] : op[7:4] == 4'hF ? {b[7:0], 8'h00} : a ^ ~b;
    endcase
  endfunction
  function automatic logic [4:0] alu_flags(logic [7:0] op, logic [DW-1:0] a, logic [DW-1:0] b);
    logic [DW:0]   s;
    logic [DW-1:0] r;
    s = {1'b0, a} + {1'b0, b};
    r = alu_res(op, a, b);
    return {r[DW-1], op == 8'h0B ? a == b : r == '0, 1'b0, a < b, s[DW]};
  endfunction
  function automatic int cls_of(logic [7:0] op);
    if (op == 8'h0B) return 1;
    if (op == 8'h44) return 2;
    if (op inside {8'h01, 8'h02, 8'h03, 8'h05, 8'h06, 8'h09, 8'h0D} || op[7:4] == 4'h8 || op[7:4] == 4'hF) return 0;
    return 3;
  endfunction
  assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
  assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
  always @(posedge clock) begin
    if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
    else if (pl_en) rf[pl_addr] <= pl_data;
  end
  // registered ALU: holds its result and sticky flags on the zero opcode
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      bus.alu_result <= '0;
      bus.alu_psr    <= '0;
    end else if (bus.alu_opcode != 8'h00) begin
      bus.alu_result <= alu_res(bus.alu_opcode, bus.alu_data_a, bus.alu_data_b);
      bus.alu_psr    <= alu_flags(bus.alu_opcode, bus.alu_data_a, bus.alu_data_b);
    end
  end
  // reference: t counts cycles since acceptance; write-back starts once the ALU latency has elapsed
  int            cyc = 0, acc_cnt = 0, acc_cyc = 0, t = 0, m_cls = 0;
  bit            busy = 1'b0;
  logic [7:0]    m_op = '0;
  logic [AW-1:0] m_rd = '0, m_rs = '0;
  logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
  logic [4:0]    m_flg = '0, psr_m = '0;
  logic [DW-1:0] rf_m [16] = '{default: '0};
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      busy  = 1'b0;
      t     = 0;
      psr_m = '0;
      m_rd  = '0;
      m_op  = '0;
    end else begin
      cyc++;
      if (pl_en) rf_m[pl_addr] = pl_data;
      if (busy) begin
        if (t <= LAT) t++;
        else if (m_cls != 2 || bus.st_ready) begin
          if (m_cls == 0) rf_m[m_rd] = m_res;
          if (m_op == 8'h05 || m_op == 8'h0B) psr_m = m_flg;
          busy = 1'b0;
        end
      end else if (bus.instr_valid) begin
        busy    = 1'b1;
        t       = 0;
        m_op    = bus.instr_op;
        m_rd    = bus.instr_rd;
        m_rs    = bus.instr_rs;
        m_a     = rf_m[bus.instr_rd];
        m_b     = rf_m[bus.instr_rs];
        m_cls   = cls_of(bus.instr_op);
        m_res   = alu_res(bus.instr_op, m_a, m_b);
        m_flg   = alu_flags(bus.instr_op, m_a, m_b);
        acc_cnt++;
        acc_cyc = cyc;
      end
    end
  end
  int checks = 0, errors = 0;
  int we_cnt = 0, we_cyc = 0, st_cnt = 0, beef_cnt = 0, ill_cnt = 0, rdy_low = 0;
  logic [AW-1:0] lw_addr = '0;
  logic [DW-1:0] lw_data = '0;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask
  task automatic compare();
    bit iss, wb;
    iss = busy && t == 0;
    wb  = busy && t > LAT;
    chk("instr_ready", bus.instr_ready, reset && !busy);
    chk("alu_opcode", bus.alu_opcode, iss ? m_op : 8'h00);
    if (iss) begin
      chk("rf_raddr_a", bus.rf_raddr_a, m_rd);
      chk("rf_raddr_b", bus.rf_raddr_b, m_rs);
      chk("alu_data_a", bus.alu_data_a, m_a);
      chk("alu_data_b", bus.alu_data_b, m_b);
    end
    chk("rf_we", bus.rf_we, wb && m_cls == 0);
    if (wb && m_cls == 0) begin
      chk("rf_waddr", bus.rf_waddr, m_rd);
      chk("rf_wdata", bus.rf_wdata, m_res);
    end
    chk("st_valid", bus.st_valid, wb && m_cls == 2);
    if (wb && m_cls == 2) chk("st_data", bus.st_data, m_res);
    chk("illegal", bus.illegal, wb && m_cls == 3);
    chk("psr_q", bus.psr_q, psr_m);
    if (bus.rf_we === 1'b1) begin
      we_cnt++;
      we_cyc  = cyc;
      lw_addr = bus.rf_waddr;
      lw_data = bus.rf_wdata;
    end
    if (bus.st_valid === 1'b1) begin
      st_cnt++;
      if (bus.st_data == 16'hBEEF) beef_cnt++;
    end
    if (bus.illegal === 1'b1) ill_cnt++;
    if (reset && bus.instr_ready !== 1'b1) rdy_low++;
  endtask
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clock);
      #2;
    end
  endtask
  task automatic wait_acc(int target);
    for (int i = 0; i < 40 && acc_cnt < target; i++) tick(1);
  endtask
  task automatic wait_idle();
    for (int i = 0; i < 60 && busy; i++) tick(1);
  endtask
  task automatic set_reg(logic [AW-1:0] a, logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    tick(1);
    pl_en = 1'b0;
  endtask
  task automatic issue(logic [7:0] op, logic [AW-1:0] rd, logic [AW-1:0] rs);
    bus.instr_op    = op;
    bus.instr_rd    = rd;
    bus.instr_rs    = rs;
    bus.instr_valid = 1'b1;
    wait_acc(acc_cnt + 1);
    bus.instr_valid = 1'b0;
  endtask
  initial begin
    int a_c, r0, w0, s0, b0, i0, n, c1, c2;
    bus.instr_valid = 1'b0;
    bus.instr_op    = '0;
    bus.instr_rd    = '0;
    bus.instr_rs    = '0;
    bus.st_ready    = 1'b0;
    #1 reset = 1'b0;
    fork
      forever begin
        @(negedge clock);
        compare();
      end
    join_none
    tick(3);
    chk("reset_psr", bus.psr_q, 5'h00);
    chk("reset_rf_we", bus.rf_we, 1'b0);
    reset = 1'b1;
    #1 chk("reset_release_ready", bus.instr_ready, 1'b1);
    tick(1);
    // 1: ADD latency, data and flags
    set_reg(4'd1, 16'h0003);
    set_reg(4'd2, 16'h0004);
    r0 = rdy_low;
    issue(8'h05, 4'd1, 4'd2);
    a_c = acc_cyc;
    wait_idle();
    chk("t1_we_latency", we_cyc - a_c, 2);
    chk("t1_waddr", lw_addr, 4'd1);
    chk("t1_wdata", lw_data, 16'h0007);
    chk("t1_psr", bus.psr_q, 5'h02);
    chk("t1_ready_low", rdy_low - r0, 3);
    // 2: CMP commits Z without writing; ADDU leaves PSR alone
    set_reg(4'd3, 16'h1234);
    set_reg(4'd4, 16'h1234);
    w0 = we_cnt;
    issue(8'h0B, 4'd3, 4'd4);
    wait_idle();
    chk("t2_cmp_no_we", we_cnt - w0, 0);
    chk("t2_cmp_psr", bus.psr_q, 5'h08);
    issue(8'h06, 4'd3, 4'd4);
    wait_idle();
    chk("t2_addu_psr", bus.psr_q, 5'h08);
    // 3: STORE held through four cycles of back-pressure
    set_reg(4'd5, 16'hBEEF);
    w0 = we_cnt;
    s0 = st_cnt;
    b0 = beef_cnt;
    issue(8'h44, 4'd5, 4'd0);
    tick(6);
    bus.st_ready = 1'b1;
    wait_idle();
    bus.st_ready = 1'b0;
    chk("t3_st_cycles", st_cnt - s0, 5);
    chk("t3_st_data", beef_cnt - b0, 5);
    chk("t3_no_we", we_cnt - w0, 0);
    // 4: dependent back-to-back ADDU with valid held
    set_reg(4'd1, 16'h0001);
    set_reg(4'd2, 16'h0002);
    n = acc_cnt;
    bus.instr_op    = 8'h06;
    bus.instr_rd    = 4'd1;
    bus.instr_rs    = 4'd2;
    bus.instr_valid = 1'b1;
    wait_acc(n + 1);
    c1 = acc_cyc;
    wait_acc(n + 2);
    c2 = acc_cyc;
    bus.instr_valid = 1'b0;
    wait_idle();
    chk("t4_accept_spacing", c2 - c1, 4);
    chk("t4_dep_result", rf[1], 16'h0005);
    // 5: unsupported opcode
    i0 = ill_cnt;
    w0 = we_cnt;
    s0 = st_cnt;
    issue(8'h07, 4'd1, 4'd2);
    wait_idle();
    chk("t5_illegal_pulse", ill_cnt - i0, 1);
    chk("t5_no_we", we_cnt - w0, 0);
    chk("t5_no_st", st_cnt - s0, 0);
    chk("t5_psr_held", bus.psr_q, 5'h08);
    // 6: reset during EXEC abandons the SUB
    set_reg(4'd1, 16'h0009);
    set_reg(4'd2, 16'h0004);
    w0 = we_cnt;
    issue(8'h09, 4'd1, 4'd2);
    tick(1);
    reset = 1'b0;
    #1;
    chk("t6_ready_in_reset", bus.instr_ready, 1'b0);
    chk("t6_opcode_in_reset", bus.alu_opcode, 8'h00);
    chk("t6_we_in_reset", bus.rf_we, 1'b0);
    chk("t6_psr_in_reset", bus.psr_q, 5'h00);
    tick(2);
    reset = 1'b1;
    #1 chk("t6_ready_after", bus.instr_ready, 1'b1);
    tick(4);
    chk("t6_no_we", we_cnt - w0, 0);
    chk("t6_rf_untouched", rf[1], 16'h0009);
    // random traffic with occasional resets
    for (int i = 0; i < 16; i++) set_reg(AW'(i), DW'($urandom));
    for (int i = 0; i < 3000; i++) begin
      bus.instr_valid = $urandom_range(0, 2) != 0;
      case ($urandom_range(0, 11))
        0: bus.instr_op = 8'h01;
        1: bus.instr_op = 8'h02;
        2: bus.instr_op = 8'h03;
        3: bus.instr_op = 8'h05;
        4: bus.instr_op = 8'h06;
        5: bus.instr_op = 8'h09;
        6: bus.instr_op = 8'h0B;
        7: bus.instr_op = 8'h0D;
        8: bus.instr_op = 8'h44;
        9: bus.instr_op = {4'h8, 4'($urandom)};
        10: bus.instr_op = {4'hF, 4'($urandom)};
        default: bus.instr_op = 8'($urandom);
      endcase
      bus.instr_rd = AW'($urandom);
      bus.instr_rs = AW'($urandom);
      bus.st_ready = $urandom_range(0, 1) == 1;
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
      end else tick(1);
    end
    bus.instr_valid = 1'b0;
    bus.st_ready    = 1'b1;
    wait_idle();
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
